// File: rtl/framebuffer_stream_loader_pkg.sv
// Shared definitions for the framebuffer stream path: FSM states, load result
// codes and the geometry derivations used by both the framebuffer and the loader.
package framebuffer_stream_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LS_OK           = 2'd0,
    LS_EARLY_LAST   = 2'd1,
    LS_MISSING_LAST = 2'd2
  } load_status_e;

  function automatic int calc_pixel_per_beat(input int stream_width, input int pixel_width);
    return stream_width / pixel_width;
  endfunction

  // Word address width of the frame RAM: pixel index width minus the pixel-in-beat bits.
  function automatic int calc_mem_addr_width(input int frame_size, input int stream_width,
                                             input int pixel_width);
    int ppb;
    ppb = stream_width / pixel_width;
    return ($clog2(frame_size * pixel_width / 8) - 1) - $clog2(ppb);
  endfunction

  function automatic int calc_frame_beats(input int frame_size, input int stream_width,
                                          input int pixel_width);
    return frame_size / (stream_width / pixel_width);
  endfunction

endpackage

// File: rtl/framebuffer_stream_loader_dpram.sv
// Simple dual-port RAM: one strobed write port, one read port with a registered
// output. Contents are never cleared.
module DualPortRam #(
  parameter int MEM_SIZE_BYTES     = 15,
  parameter int MEM_WIDTH          = 16,
  parameter int WRITE_STROBE_WIDTH = 4,
  localparam int WORD_ADDR_WIDTH   = MEM_SIZE_BYTES - $clog2(MEM_WIDTH / 8),
  localparam int STRB_WIDTH        = MEM_WIDTH / WRITE_STROBE_WIDTH
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [WORD_ADDR_WIDTH-1:0] wr_addr,
  input  logic [STRB_WIDTH-1:0]      wr_strb,
  input  logic [MEM_WIDTH-1:0]       wr_data,
  input  logic [WORD_ADDR_WIDTH-1:0] rd_addr,
  output logic [MEM_WIDTH-1:0]       rd_data
);

  logic [MEM_WIDTH-1:0] mem [2**WORD_ADDR_WIDTH];
  logic [MEM_WIDTH-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int s = 0; s < STRB_WIDTH; s++) begin
        if (wr_strb[s]) begin
          mem[wr_addr][s*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH] <=
            wr_data[s*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
        end
      end
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_stream_loader.sv
// Receives one frame over AXI-Stream and writes it linearly into a local RAM;
// pixels are read back through a two-cycle fragment read port.
module framebuffer_stream_loader
  import framebuffer_stream_loader_pkg::*;
#(
  parameter int FRAME_SIZE           = 16384,
  parameter int STREAM_WIDTH         = 16,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int SUB_PIXEL_WIDTH      = 4,
  localparam int PIXEL_WIDTH         = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
  localparam int ADDR_WIDTH          = $clog2(FRAME_SIZE * PIXEL_WIDTH / 8) - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    apply,
  output logic                    applied,
  input  logic                    cmdLoad,
  output logic [1:0]              loadStatus,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  input  logic [ADDR_WIDTH-1:0]   fragIndexRead,
  output logic [PIXEL_WIDTH-1:0]  fragOut,
  output logic [1:0]              dbg_state
);

  localparam int PIXEL_PER_BEAT = calc_pixel_per_beat(STREAM_WIDTH, PIXEL_WIDTH);
  localparam int MEM_ADDR_WIDTH = calc_mem_addr_width(FRAME_SIZE, STREAM_WIDTH, PIXEL_WIDTH);
  localparam int FRAME_BEATS    = calc_frame_beats(FRAME_SIZE, STREAM_WIDTH, PIXEL_WIDTH);
  localparam int SEL_WIDTH      = (PIXEL_PER_BEAT > 1) ? $clog2(PIXEL_PER_BEAT) : 1;
  localparam int STRB_WIDTH     = STREAM_WIDTH / SUB_PIXEL_WIDTH;
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_BEAT = MEM_ADDR_WIDTH'(FRAME_BEATS - 1);

  state_e                    state_q, state_d;
  load_status_e              status_q, status_d;
  logic [MEM_ADDR_WIDTH-1:0] counter_q, counter_d;
  logic                      tready_q, tready_d;
  logic                      applied_q, applied_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic [PIXEL_WIDTH-1:0]    frag_q, frag_d;

  logic                      wr_en;
  logic                      handshake;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr;
  logic [STREAM_WIDTH-1:0]   rd_data;

  assign handshake = s_axis_tvalid & tready_q;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    counter_d = counter_q;
    tready_d  = tready_q;
    applied_d = applied_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (apply && cmdLoad) begin
          state_d   = ST_LOAD;
          counter_d = '0;
          status_d  = LS_OK;
          tready_d  = 1'b1;
          applied_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          wr_en     = 1'b1;
          counter_d = counter_q + 1'b1;
          if (s_axis_tlast) begin
            state_d   = ST_IDLE;
            tready_d  = 1'b0;
            applied_d = 1'b1;
            if (counter_q != LAST_BEAT) status_d = LS_EARLY_LAST;
          end else if (counter_q == LAST_BEAT) begin
            // Frame is full but upstream has not ended it: swallow the rest.
            state_d  = ST_DRAIN;
            status_d = LS_MISSING_LAST;
          end
        end
      end
      ST_DRAIN: begin
        if (handshake && s_axis_tlast) begin
          state_d   = ST_IDLE;
          tready_d  = 1'b0;
          applied_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tready_d  = 1'b0;
        applied_d = 1'b1;
      end
    endcase
  end

  // Read path: word address goes to the RAM, pixel select is delayed to match it.
  always_comb begin
    rd_addr = MEM_ADDR_WIDTH'(fragIndexRead / PIXEL_PER_BEAT);
    sel_d   = SEL_WIDTH'(fragIndexRead % PIXEL_PER_BEAT);
    frag_d  = rd_data[sel_q * PIXEL_WIDTH +: PIXEL_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      status_q  <= LS_OK;
      counter_q <= '0;
      tready_q  <= 1'b0;
      applied_q <= 1'b1;
      sel_q     <= '0;
      frag_q    <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      counter_q <= counter_d;
      tready_q  <= tready_d;
      applied_q <= applied_d;
      sel_q     <= sel_d;
      frag_q    <= frag_d;
    end
  end

  DualPortRam #(
    .MEM_SIZE_BYTES    ($clog2(FRAME_SIZE * PIXEL_WIDTH / 8)),
    .MEM_WIDTH         (STREAM_WIDTH),
    .WRITE_STROBE_WIDTH(SUB_PIXEL_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(counter_q),
    .wr_strb({STRB_WIDTH{1'b1}}),
    .wr_data(s_axis_tdata),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign s_axis_tready = tready_q;
  assign applied       = applied_q;
  assign loadStatus    = status_q;
  assign fragOut       = frag_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_framebuffer_stream_loader.sv
// Directed bench for framebuffer_stream_loader: frame loads with a reference
// model of the write rules, and pipelined fragment reads checked via a queue.
module tb_framebuffer_stream_loader;
  import framebuffer_stream_loader_pkg::*;

  localparam int FRAME_SIZE = 16;
  localparam int SW         = 32;
  localparam int PW         = 16;
  localparam int BEATS      = 8;
  localparam int AW         = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          apply = 1'b0;
  logic          cmdLoad = 1'b0;
  logic          applied;
  logic [1:0]    loadStatus;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [SW-1:0] s_axis_tdata = '0;
  logic [AW-1:0] fragIndexRead = '0;
  logic [PW-1:0] fragOut;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] model_mem [BEATS];
  state_e        m_state  = ST_IDLE;
  load_status_e  m_status = LS_OK;
  int            m_count  = 0;
  logic [PW-1:0] exp_q [$];

  framebuffer_stream_loader #(
    .FRAME_SIZE          (FRAME_SIZE),
    .STREAM_WIDTH        (SW),
    .NUMBER_OF_SUB_PIXELS(4),
    .SUB_PIXEL_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .apply        (apply),
    .applied      (applied),
    .cmdLoad      (cmdLoad),
    .loadStatus   (loadStatus),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tdata (s_axis_tdata),
    .fragIndexRead(fragIndexRead),
    .fragOut      (fragOut),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_tready"},  32'(s_axis_tready), 32'(m_state != ST_IDLE));
    check({tag, "_applied"}, 32'(applied),       32'(m_state == ST_IDLE));
    check({tag, "_status"},  32'(loadStatus),    32'(m_status));
    check({tag, "_state"},   32'(dbg_state),     32'(m_state));
  endtask

  // reference model of what an accepted beat does
  task automatic model_beat(input logic [SW-1:0] data, input logic last);
    case (m_state)
      ST_LOAD: begin
        model_mem[m_count] = data;
        if (last) begin
          m_state = ST_IDLE;
          if (m_count != BEATS - 1) m_status = LS_EARLY_LAST;
        end else if (m_count == BEATS - 1) begin
          m_state  = ST_DRAIN;
          m_status = LS_MISSING_LAST;
        end
        m_count++;
      end
      ST_DRAIN: if (last) m_state = ST_IDLE;
      default: ;
    endcase
  endtask

  // driver tasks: all start and end at a falling edge
  task automatic start_load(input logic cmd);
    apply   = 1'b1;
    cmdLoad = cmd;
    @(posedge clk);
    if (m_state == ST_IDLE && cmd) begin
      m_state  = ST_LOAD;
      m_count  = 0;
      m_status = LS_OK;
    end
    @(negedge clk);
    apply   = 1'b0;
    cmdLoad = 1'b0;
  endtask

  task automatic send_beat(input logic [SW-1:0] data, input logic last, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      check("tready_in_gap", 32'(s_axis_tready), 32'(1));
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    waited = 0;
    while (!s_axis_tready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check("beat_accepted", 32'(s_axis_tready), 32'(1));
    if (s_axis_tready) begin
      @(posedge clk);
      model_beat(data, last);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // one index per cycle; each result is compared two cycles after its index
  task automatic read_all(input string tag);
    for (int cyc = 0; cyc < 2 * BEATS + 2; cyc++) begin
      if (cyc >= 2) check(tag, 32'(fragOut), 32'(exp_q.pop_front()));
      if (cyc < 2 * BEATS) begin
        logic [SW-1:0] w;
        w = model_mem[cyc / 2];
        fragIndexRead = AW'(cyc);
        exp_q.push_back(w[(cyc % 2) * PW +: PW]);
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [SW-1:0] nominal_beat(input int i);
    return 32'h0001_0000 + 32'h0002_0002 * i;
  endfunction

  initial begin
    // reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tready",  32'(s_axis_tready), 32'(0));
    check("rst_applied", 32'(applied),       32'(1));
    check("rst_status",  32'(loadStatus),    32'(0));
    check("rst_fragout", 32'(fragOut),       32'(0));
    reset = 1'b0;
    @(negedge clk);

    // nominal load, back-to-back beats; beat offered with apply is not taken
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_BEEF;
    start_load(1'b1);
    s_axis_tvalid = 1'b0;
    check_ctrl("nom_start");
    for (int i = 0; i < BEATS; i++) send_beat(nominal_beat(i), i == BEATS - 1, 0);
    check_ctrl("nom_done");
    check("nom_status_ok", 32'(loadStatus), 32'(LS_OK));
    read_all("nom_frag");
    fragIndexRead = 4'd5;
    @(negedge clk); @(negedge clk);
    check("nom_frag_idx5", 32'(fragOut), 32'h0005);

    // backpressure: random tvalid gaps, same frame contents
    start_load(1'b1);
    for (int i = 0; i < BEATS; i++)
      send_beat(nominal_beat(i), i == BEATS - 1, $urandom_range(0, 3));
    check_ctrl("bp_done");
    read_all("bp_frag");

    // early tlast on beat 4: beats 5-7 keep the previous frame
    start_load(1'b1);
    for (int i = 0; i < 5; i++) send_beat(32'hA0A0_0000 + 32'(i * 32'h0101_0101), i == 4, 0);
    check_ctrl("early_done");
    check("early_status", 32'(loadStatus), 32'(LS_EARLY_LAST));
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("early_tready_low", 32'(s_axis_tready), 32'(0));
    end
    s_axis_tvalid = 1'b0;
    read_all("early_frag");

    // apply without cmdLoad is ignored and keeps the status
    start_load(1'b0);
    check_ctrl("nocmd");
    check("nocmd_status_kept", 32'(loadStatus), 32'(LS_EARLY_LAST));

    // missing tlast: 11 beats, only the first 8 land in RAM
    start_load(1'b1);
    for (int i = 0; i < 10; i++) begin
      send_beat(32'h5000_0000 + 32'(i * 32'h0011_0011), 1'b0, 0);
      if (i == 7) check_ctrl("miss_drain");
    end
    check("miss_applied_low", 32'(applied), 32'(0));
    send_beat(32'h5555_5555, 1'b1, 0);
    check_ctrl("miss_done");
    check("miss_status", 32'(loadStatus), 32'(LS_MISSING_LAST));
    read_all("miss_frag");

    // reset in the middle of a load, then a full load
    start_load(1'b1);
    for (int i = 0; i < 3; i++) send_beat(32'hCC00_0000 + 32'(i), 1'b0, 0);
    reset = 1'b1;
    @(posedge clk);
    m_state  = ST_IDLE;
    m_status = LS_OK;
    m_count  = 0;
    @(negedge clk);
    check_ctrl("midrst");
    reset = 1'b0;
    @(negedge clk);
    start_load(1'b1);
    for (int i = 0; i < BEATS; i++) send_beat(32'h7700_1100 + 32'(i * 32'h0003_0007), i == BEATS - 1, 0);
    check_ctrl("post_rst_done");
    read_all("post_rst_frag");

    // apply during LOAD does not restart the counter
    start_load(1'b1);
    for (int i = 0; i < 2; i++) send_beat(32'h1234_0000 + 32'(i), 1'b0, 0);
    start_load(1'b1);
    check_ctrl("apply_in_load");
    for (int i = 2; i < BEATS; i++) send_beat(32'h1234_0000 + 32'(i), i == BEATS - 1, 0);
    check_ctrl("apply_in_load_done");
    check("apply_in_load_status", 32'(loadStatus), 32'(LS_OK));
    read_all("apply_in_load_frag");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
